// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift-register family (PISO/SISO/SIPO).
// Holds the FSM state encodings and the default word width.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int SERIAL_WIDTH = 8;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmit stage: accepts a WIDTH-bit word on a
// valid/ready handshake and emits it LSB first with a per-bit enable strobe.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_en,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]       gap_cnt, gap_cnt_nxt;
  logic             last_bit;
  logic             accept;

  assign last_bit  = (state == ST_SHIFT) && (bit_cnt == LAST);
  assign din_ready = !reset_p && ((state == ST_IDLE) || (last_bit && (GAP == 0)));
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt   = ST_SHIFT;
          sreg_nxt    = din;
          bit_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        sreg_nxt    = sreg >> 1;
        bit_cnt_nxt = bit_cnt + CW'(1);
        if (bit_cnt == LAST) begin
          bit_cnt_nxt = '0;
          if (GAP > 0) begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = GAP_LOAD;
          end else if (accept) begin
            sreg_nxt = din;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // The IDLE cycle that follows counts as the final idle slot, so the
        // next word can start exactly WIDTH+GAP cycles after the previous one.
        if (gap_cnt <= 8'd1) begin
          state_nxt   = ST_IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      dout    <= 1'b0;
      dout_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      dout    <= (state_nxt == ST_SHIFT) ? sreg_nxt[0] : 1'b0;
      dout_en <= (state_nxt == ST_SHIFT);
      busy    <= (state_nxt != ST_IDLE);
      done    <= (state_nxt == ST_SHIFT) && (bit_cnt_nxt == LAST);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one GAP=0 and one GAP=3 instance,
// plus a behavioural SIPO on the GAP=0 output for loopback.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic [7:0] din0 = '0, din3 = '0;
  logic       dv0 = 1'b0, dv3 = 1'b0;
  logic       din_ready0, dout0, dout_en0, busy0, done0;
  logic       din_ready3, dout3, dout_en3, busy3, done3;
  logic [7:0] sipo_q = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .GAP(0)) u_dut0 (
    .clk(clk), .reset_p(reset_p), .din(din0), .din_valid(dv0),
    .din_ready(din_ready0), .dout(dout0), .dout_en(dout_en0),
    .busy(busy0), .done(done0)
  );

  piso_serializer #(.WIDTH(8), .GAP(3)) u_dut3 (
    .clk(clk), .reset_p(reset_p), .din(din3), .din_valid(dv3),
    .din_ready(din_ready3), .dout(dout3), .dout_en(dout_en3),
    .busy(busy3), .done(done3)
  );

  // Downstream SIPO model: LSB arrives first, so shift in from the top.
  always @(posedge clk)
    if (dout_en0) sipo_q <= {dout0, sipo_q[7:1]};

  task automatic test_reset;
    reset_p = 1'b1;
    din0 = 8'h03;
    dv0 = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({dout0, dout_en0, busy0, done0, din_ready0} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_outs0 got=%b exp=00000", {dout0, dout_en0, busy0, done0, din_ready0});
    end
    vectors++;
    if ({dout3, dout_en3, busy3, done3, din_ready3} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_outs3 got=%b exp=00000", {dout3, dout_en3, busy3, done3, din_ready3});
    end
    reset_p = 1'b0;
    #1;
    vectors++;
    if (din_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got=%b exp=1", din_ready0);
    end
    @(negedge clk);
    dv0 = 1'b0;
    vectors++;
    if ({dout0, dout_en0, busy0, done0} !== 4'b1110) begin
      miscompares++;
      $display("FAIL valid_held_first_bit got=%b exp=1110", {dout0, dout_en0, busy0, done0});
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_single_word;
    logic [7:0] w;
    w = 8'hBC;
    din0 = w;
    dv0 = 1'b1;
    #1;
    vectors++;
    if (din_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready got=%b exp=1", din_ready0);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dv0 = 1'b0;
      vectors++;
      if ({dout0, dout_en0, busy0, done0} !== {w[k], 1'b1, 1'b1, (k == 7)}) begin
        miscompares++;
        $display("FAIL single_bit%0d got=%b exp=%b", k, {dout0, dout_en0, busy0, done0},
                 {w[k], 1'b1, 1'b1, (k == 7)});
      end
    end
    @(negedge clk);
    vectors++;
    if ({dout0, dout_en0, busy0, done0, din_ready0} !== 5'b00001) begin
      miscompares++;
      $display("FAIL single_idle got=%b exp=00001", {dout0, dout_en0, busy0, done0, din_ready0});
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] stream;
    stream = 16'h5ABC;
    din0 = 8'hBC;
    dv0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) din0 = 8'h5A;
      if (k == 8) dv0 = 1'b0;
      vectors++;
      if ({dout0, dout_en0, done0} !== {stream[k], 1'b1, (k == 7 || k == 15)}) begin
        miscompares++;
        $display("FAIL b2b_bit%0d got=%b exp=%b", k, {dout0, dout_en0, done0},
                 {stream[k], 1'b1, (k == 7 || k == 15)});
      end
      if (k == 7) begin
        vectors++;
        if (din_ready0 !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready_last got=%b exp=1", din_ready0);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if ({dout_en0, busy0, done0} !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_idle got=%b exp=000", {dout_en0, busy0, done0});
    end
  endtask

  task automatic test_gap;
    logic [7:0] w;
    logic       exp_en;
    logic       exp_bit;
    int         low_cnt;
    low_cnt = 0;
    din3 = 8'hBC;
    dv3 = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i == 0) din3 = 8'h5A;
      if (i == 12) dv3 = 1'b0;
      w = (i < 8) ? 8'hBC : 8'h5A;
      exp_en = (i < 8) || (i >= 11);
      exp_bit = (i < 8) ? w[i] : ((i >= 11) ? w[i-11] : 1'b0);
      if (!dout_en3) low_cnt++;
      vectors++;
      if ({dout3, dout_en3} !== {exp_bit, exp_en}) begin
        miscompares++;
        $display("FAIL gap_cycle%0d got=%b exp=%b", i, {dout3, dout_en3}, {exp_bit, exp_en});
      end
      if (i == 8 || i == 9) begin
        vectors++;
        if ({busy3, din_ready3} !== 2'b10) begin
          miscompares++;
          $display("FAIL gap_busy_ready%0d got=%b exp=10", i, {busy3, din_ready3});
        end
      end
    end
    vectors++;
    if (low_cnt != 3) begin
      miscompares++;
      $display("FAIL gap_low_cycles got=%0d exp=3", low_cnt);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] w;
    int         en_seen;
    w = 8'hBC;
    en_seen = 0;
    din0 = w;
    dv0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dv0 = 1'b0;
      vectors++;
      if ({dout0, dout_en0} !== {w[k], 1'b1}) begin
        miscompares++;
        $display("FAIL midrst_bit%0d got=%b exp=%b", k, {dout0, dout_en0}, {w[k], 1'b1});
      end
    end
    reset_p = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dout0, dout_en0, busy0, done0, din_ready0} !== 5'b00000) begin
      miscompares++;
      $display("FAIL midrst_outs got=%b exp=00000", {dout0, dout_en0, busy0, done0, din_ready0});
    end
    reset_p = 1'b0;
    #1;
    vectors++;
    if (din_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_ready got=%b exp=1", din_ready0);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dout_en0) en_seen++;
    end
    vectors++;
    if (en_seen != 0) begin
      miscompares++;
      $display("FAIL midrst_no_bits got=%0d exp=0", en_seen);
    end
  endtask

  task automatic test_loopback;
    bit got_done;
    got_done = 1'b0;
    din0 = 8'hBC;
    dv0 = 1'b1;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      dv0 = 1'b0;
      if (done0) got_done = 1'b1;
    end
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL loopback_done got=timeout exp=pulse");
    end else begin
      @(negedge clk);
      if (sipo_q !== 8'hBC) begin
        miscompares++;
        $display("FAIL loopback_q got=%h exp=bc", sipo_q);
      end
    end
  endtask

  task automatic test_din_change;
    logic [7:0] w;
    w = 8'hBC;
    din0 = w;
    dv0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dv0 = 1'b0;
      din0 = 8'($urandom);
      vectors++;
      if ({dout0, dout_en0} !== {w[k], 1'b1}) begin
        miscompares++;
        $display("FAIL dinchg_bit%0d got=%b exp=%b", k, {dout0, dout_en0}, {w[k], 1'b1});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_reset_mid_word();
    test_loopback();
    test_din_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
